// File: rtl/rom_download_router.sv
// Routes the hps_io ioctl byte stream into region-selected ROM writes, applies back-pressure
// while the target is busy, and latches DIP / PCB-variant bytes. Reports load status and checksum.
module rom_download_router #(
  parameter int unsigned          NREG       = 6,
  parameter int unsigned          AW         = 25,
  parameter logic [NREG*AW-1:0]   REGION_END = {25'h0030000, 25'h0028000, 25'h0020000,
                                                25'h0018000, 25'h0010000, 25'h0008000}
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ioctl_download,
  input  logic [7:0]      ioctl_index,
  input  logic            ioctl_wr,
  input  logic [AW-1:0]   ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic            ioctl_wait,
  input  logic            tgt_busy,
  output logic            dn_wr,
  output logic [NREG-1:0] dn_sel,
  output logic [AW-1:0]   dn_addr,
  output logic [7:0]      dn_data,
  output logic [63:0]     dip_sw,
  output logic [7:0]      pcb,
  output logic            rom_ready,
  output logic            load_done,
  output logic            load_err,
  output logic [AW-1:0]   byte_cnt,
  output logic [7:0]      checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_DONE} state_t;

  state_t          r_state, w_next;
  logic            r_rom_q;
  logic            r_pend;
  logic [NREG-1:0] r_sel;
  logic [AW-1:0]   r_off;
  logic [7:0]      r_data;
  logic            r_load_err;
  logic            r_rom_ready;
  logic [AW-1:0]   r_byte_cnt;
  logic [7:0]      r_checksum;
  logic [63:0]     r_dip;
  logic [7:0]      r_pcb;

  logic            w_rom;
  logic            w_start;
  logic            w_stall;
  logic            w_issue;
  logic            w_cap;
  logic            w_found;
  logic [NREG-1:0] w_hit;
  logic [AW-1:0]   w_base;
  logic [AW-1:0]   w_lo;

  assign w_rom   = ioctl_download & (ioctl_index == 8'd0);
  assign w_start = w_rom & ~r_rom_q;
  assign w_stall = r_pend & tgt_busy;
  assign w_issue = r_pend & ~tgt_busy;
  assign w_cap   = (r_state == S_LOAD) & w_rom & ioctl_wr & ~w_stall;

  // Lowest region whose exclusive bound exceeds the address; base is the previous bound.
  always_comb begin
    w_found = 1'b0;
    w_hit   = '0;
    w_base  = '0;
    w_lo    = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (!w_found) begin
        if (ioctl_addr < REGION_END[k*AW +: AW]) begin
          w_found  = 1'b1;
          w_hit[k] = 1'b1;
          w_base   = w_lo;
        end else begin
          w_lo = REGION_END[k*AW +: AW];
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_LOAD;
      S_LOAD:  if (w_stall) w_next = S_HOLD;
               else if (!ioctl_download) w_next = S_DONE;
      S_HOLD:  if (!tgt_busy) w_next = ioctl_download ? S_LOAD : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_rom_q resets high so a download still active across reset cannot restart a load.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rom_q     <= 1'b1;
      r_pend      <= 1'b0;
      r_sel       <= '0;
      r_off       <= '0;
      r_data      <= '0;
      r_load_err  <= 1'b0;
      r_rom_ready <= 1'b0;
      r_byte_cnt  <= '0;
      r_checksum  <= '0;
    end else begin
      r_state <= w_next;
      r_rom_q <= w_rom;
      if (w_cap && w_found) begin
        r_pend <= 1'b1;
        r_sel  <= w_hit;
        r_off  <= ioctl_addr - w_base;
        r_data <= ioctl_dout;
      end else if (w_issue) begin
        r_pend <= 1'b0;
      end
      if (w_cap && !w_found) r_load_err <= 1'b1;
      if (r_state == S_IDLE && w_start) begin
        r_byte_cnt  <= '0;
        r_checksum  <= '0;
        r_load_err  <= 1'b0;
        r_rom_ready <= 1'b0;
      end else if (w_issue) begin
        if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 1'b1;
        r_checksum <= r_checksum + r_data;
      end
      if (r_state == S_DONE) r_rom_ready <= ~r_load_err;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dip <= '0;
      r_pcb <= '0;
    end else if (ioctl_wr) begin
      if (ioctl_index == 8'd254 && ioctl_addr < AW'(8))
        r_dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      if (ioctl_index == 8'd1) r_pcb <= ioctl_dout;
    end
  end

  assign ioctl_wait = w_stall;
  assign dn_wr      = w_issue;
  assign dn_sel     = w_issue ? r_sel : '0;
  assign dn_addr    = r_off;
  assign dn_data    = r_data;
  assign dip_sw     = r_dip;
  assign pcb        = r_pcb;
  assign rom_ready  = r_rom_ready;
  assign load_done  = (r_state == S_DONE);
  assign load_err   = r_load_err;
  assign byte_cnt   = r_byte_cnt;
  assign checksum   = r_checksum;

endmodule

// File: tb/tb_rom_download_router.sv
// Bench for rom_download_router: 3-region map, scoreboard on the write strobe, table-driven decode
// vectors plus hand-written busy, out-of-range, DIP, full-load and reset sequences.
module tb_rom_download_router;

  localparam int unsigned NREG = 3;
  localparam int unsigned AW   = 25;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            ioctl_download;
  logic [7:0]      ioctl_index;
  logic            ioctl_wr;
  logic [AW-1:0]   ioctl_addr;
  logic [7:0]      ioctl_dout;
  logic            ioctl_wait;
  logic            tgt_busy;
  logic            dn_wr;
  logic [NREG-1:0] dn_sel;
  logic [AW-1:0]   dn_addr;
  logic [7:0]      dn_data;
  logic [63:0]     dip_sw;
  logic [7:0]      pcb;
  logic            rom_ready;
  logic            load_done;
  logic            load_err;
  logic [AW-1:0]   byte_cnt;
  logic [7:0]      checksum;

  rom_download_router #(
    .NREG       (NREG),
    .AW         (AW),
    .REGION_END ({25'h0010000, 25'h000C000, 25'h0008000})
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .tgt_busy       (tgt_busy),
    .dn_wr          (dn_wr),
    .dn_sel         (dn_sel),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dip_sw         (dip_sw),
    .pcb            (pcb),
    .rom_ready      (rom_ready),
    .load_done      (load_done),
    .load_err       (load_err),
    .byte_cnt       (byte_cnt),
    .checksum       (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [NREG-1:0] sel;
    logic [AW-1:0]   addr;
    logic [7:0]      data;
  } wr_t;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [7:0]      data;
    logic [NREG-1:0] exp_sel;
    logic [AW-1:0]   exp_addr;
  } vec_t;

  wr_t         sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Independent region model for the full-load sweep.
  function automatic wr_t model(input logic [AW-1:0] a, input logic [7:0] d);
    wr_t w;
    w.data = d;
    if (a < 25'h8000) begin
      w.sel = 3'b001; w.addr = a;
    end else if (a < 25'hC000) begin
      w.sel = 3'b010; w.addr = a - 25'h8000;
    end else begin
      w.sel = 3'b100; w.addr = a - 25'hC000;
    end
    return w;
  endfunction

  always @(negedge clk_sys) begin
    if (dn_wr === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dn_wr: got sel=%b addr=0x%0h data=0x%0h expected no strobe at %0t",
                 dn_sel, dn_addr, dn_data, $time);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("dn_write {sel,addr,data}", {28'd0, dn_sel, dn_addr, dn_data}, {28'd0, e.sel, e.addr, e.data});
      end
    end else begin
      chk("dn_sel_idle", 64'(dn_sel), 64'd0);
    end
  end

  task automatic start_rom();
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_rom(output int pulses);
    ioctl_download = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk_sys);
      if (load_done === 1'b1) pulses++;
      tick();
    end
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    vec_t vecs[4];
    int   pulses;
    wr_t  e;

    vecs[0] = '{addr: 25'h0000, data: 8'h11, exp_sel: 3'b001, exp_addr: 25'h0000};
    vecs[1] = '{addr: 25'h7FFF, data: 8'h22, exp_sel: 3'b001, exp_addr: 25'h7FFF};
    vecs[2] = '{addr: 25'h8000, data: 8'h33, exp_sel: 3'b010, exp_addr: 25'h0000};
    vecs[3] = '{addr: 25'hC001, data: 8'h44, exp_sel: 3'b100, exp_addr: 25'h0001};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; tgt_busy = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("rst_dn_wr",     64'(dn_wr), 64'd0);
    chk("rst_wait",      64'(ioctl_wait), 64'd0);
    chk("rst_rom_ready", 64'(rom_ready), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_load_err",  64'(load_err), 64'd0);
    chk("rst_byte_cnt",  64'(byte_cnt), 64'd0);
    chk("rst_checksum",  64'(checksum), 64'd0);
    chk("rst_dip",       dip_sw, 64'd0);
    chk("rst_pcb",       64'(pcb), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Region decode, one-cycle latency.
    start_rom();
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{sel: vecs[i].exp_sel, addr: vecs[i].exp_addr, data: vecs[i].data});
      send(vecs[i].addr, vecs[i].data);
      @(negedge clk_sys);
      chk("decode_latency", 64'(dn_wr), 64'd1);
      tick();
    end
    end_rom(pulses);
    chk("tbl_done_pulses", 64'(pulses), 64'd1);
    chk("tbl_rom_ready",   64'(rom_ready), 64'd1);
    chk("tbl_byte_cnt",    64'(byte_cnt), 64'd4);
    chk("tbl_checksum",    64'(checksum), 64'hAA);

    // Target busy for three cycles.
    start_rom();
    sb.push_back('{sel: 3'b001, addr: 25'h0100, data: 8'h12});
    send(25'h0100, 8'h12);
    tgt_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      chk("busy_wait_hi", 64'(ioctl_wait), 64'd1);
      chk("busy_no_wr",   64'(dn_wr), 64'd0);
      tick();
    end
    tgt_busy = 1'b0;
    @(negedge clk_sys);
    chk("busy_wait_lo", 64'(ioctl_wait), 64'd0);
    chk("busy_wr",      64'(dn_wr), 64'd1);
    tick();
    end_rom(pulses);
    chk("busy_byte_cnt", 64'(byte_cnt), 64'd1);
    chk("busy_checksum", 64'(checksum), 64'h12);

    // Byte beyond the last region.
    start_rom();
    send(25'h10000, 8'h5A);
    @(negedge clk_sys);
    chk("oob_no_wr",    64'(dn_wr), 64'd0);
    chk("oob_load_err", 64'(load_err), 64'd1);
    tick();
    end_rom(pulses);
    chk("oob_done_pulses", 64'(pulses), 64'd1);
    chk("oob_rom_ready",   64'(rom_ready), 64'd0);
    chk("oob_byte_cnt",    64'(byte_cnt), 64'd0);

    // DIP and PCB-variant bytes.
    ioctl_download = 1'b1;
    ioctl_index = 8'd254;
    send(25'd1, 8'hA5);
    send(25'd9, 8'h11);
    ioctl_index = 8'd1;
    send(25'd0, 8'h01);
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    tick();
    chk("dip_sw",       dip_sw, 64'h0000_0000_0000_A500);
    chk("pcb",          64'(pcb), 64'h01);
    chk("dip_byte_cnt", 64'(byte_cnt), 64'd0);

    // Full 64 KiB load of 0xFF, back to back.
    start_rom();
    for (int a = 0; a < 65536; a++) begin
      e = model(AW'(a), 8'hFF);
      sb.push_back(e);
      ioctl_addr = AW'(a);
      ioctl_dout = 8'hFF;
      ioctl_wr   = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    end_rom(pulses);
    chk("full_done_pulses", 64'(pulses), 64'd1);
    chk("full_byte_cnt",    64'(byte_cnt), 64'h10000);
    chk("full_checksum",    64'(checksum), 64'h00);
    chk("full_rom_ready",   64'(rom_ready), 64'd1);
    chk("full_load_err",    64'(load_err), 64'd0);

    // Reset while holding a byte; no strobe afterwards, no restart without a fresh rise.
    start_rom();
    send(25'h0200, 8'h5A);
    tgt_busy = 1'b1;
    @(negedge clk_sys);
    chk("hold_wait", 64'(ioctl_wait), 64'd1);
    tick();
    @(negedge clk_sys);
    #1 reset = 1'b1;
    #1;
    chk("rst_hold_wait", 64'(ioctl_wait), 64'd0);
    chk("rst_hold_wr",   64'(dn_wr), 64'd0);
    tick();
    reset = 1'b0;
    tgt_busy = 1'b0;
    repeat (5) tick();
    @(negedge clk_sys);
    chk("post_rst_wait",      64'(ioctl_wait), 64'd0);
    chk("post_rst_rom_ready", 64'(rom_ready), 64'd0);
    chk("post_rst_dip",       dip_sw, 64'd0);
    tick();
    send(25'h0000, 8'h77);
    @(negedge clk_sys);
    chk("no_restart_wr", 64'(dn_wr), 64'd0);
    tick();
    ioctl_download = 1'b0;
    repeat (3) tick();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
